// File: rtl/record_fifo_if.sv
// Handshake bundle for record_fifo: word-in side, record-out side and occupancy status.
interface record_fifo_if #(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 16,
  parameter int SLOTS        = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic [WORD_SIZE-1:0]              in_data;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [WORD_SIZE*RECORD_WORDS-1:0] out_data;
  logic [$clog2(RECORD_WORDS):0]     out_len;
  logic [$clog2(SLOTS):0]            level;
  logic                              full;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len, level, full
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len, level, full
  );
endinterface

// File: rtl/record_fifo.sv
// Word-in, record-out FIFO with atomic record commit.
// Define RECORD_FIFO_SHORT_RECORD_EN to honour in_last (PAD state plus per-slot length storage).
module record_fifo #(
  parameter int                   WORD_SIZE    = 8,
  parameter int                   RECORD_WORDS = 16,
  parameter int                   SLOTS        = 8,
  parameter logic [WORD_SIZE-1:0] PAD_WORD     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  record_fifo_if.slave  bus
);
  localparam int IW = $clog2(RECORD_WORDS);
  localparam int SW = $clog2(SLOTS);
  localparam int LW = IW + 1;
  localparam int VW = SW + 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(RECORD_WORDS - 1);
  localparam logic [LW-1:0] LEN_FULL  = LW'(RECORD_WORDS);
  localparam logic [VW-1:0] LEVEL_MAX = VW'(SLOTS);

  logic [WORD_SIZE-1:0] mem [SLOTS][RECORD_WORDS];
  logic [SW-1:0]        wr_slot;
  logic [SW-1:0]        rd_slot;
  logic [IW-1:0]        idx;
  logic [VW-1:0]        level;

  logic                 in_ready_c;
  logic                 accept;
  logic                 read;
  logic                 write_en;
  logic                 commit;
  logic [WORD_SIZE-1:0] write_word;

  assign accept = bus.in_valid && in_ready_c;
  assign read   = (level != '0) && bus.out_ready;

`ifdef RECORD_FIFO_SHORT_RECORD_EN
  typedef enum logic {FILL, PAD} state_t;

  state_t        state;
  state_t        state_next;
  logic          latch_len;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] commit_len;
  logic [LW-1:0] len_mem [SLOTS];

  assign in_ready_c = rst_n && !flush && (level < LEVEL_MAX) && (state == FILL);

  // PAD finishes a short record with PAD_WORD, one word per cycle, then commits it.
  always_comb begin
    state_next = state;
    write_en   = 1'b0;
    write_word = bus.in_data;
    commit     = 1'b0;
    latch_len  = 1'b0;
    commit_len = LEN_FULL;
    case (state)
      FILL: begin
        if (accept) begin
          write_en = 1'b1;
          if (idx == IDX_LAST) begin
            commit = 1'b1;
          end else if (bus.in_last) begin
            latch_len  = 1'b1;
            state_next = PAD;
          end
        end
      end
      PAD: begin
        write_en   = !flush;
        write_word = PAD_WORD;
        commit_len = len_reg;
        if (idx == IDX_LAST) begin
          commit     = !flush;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.out_len = len_mem[rd_slot];
`else
  logic unused_in_last;

  assign unused_in_last = bus.in_last;
  assign in_ready_c     = rst_n && !flush && (level < LEVEL_MAX);

  always_comb begin
    write_en   = accept;
    write_word = bus.in_data;
    commit     = accept && (idx == IDX_LAST);
  end

  assign bus.out_len = LEN_FULL;
`endif

  // Flush outranks commit and read; storage itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot <= '0;
      rd_slot <= '0;
      idx     <= '0;
      level   <= '0;
`ifdef RECORD_FIFO_SHORT_RECORD_EN
      state   <= FILL;
      len_reg <= '0;
`endif
    end else if (flush) begin
      wr_slot <= '0;
      rd_slot <= '0;
      idx     <= '0;
      level   <= '0;
`ifdef RECORD_FIFO_SHORT_RECORD_EN
      state   <= FILL;
`endif
    end else begin
`ifdef RECORD_FIFO_SHORT_RECORD_EN
      state <= state_next;
      if (latch_len) len_reg <= {1'b0, idx} + 1'b1;
`endif
      if (write_en) idx <= commit ? '0 : idx + 1'b1;
      if (commit) wr_slot <= wr_slot + 1'b1;
      if (read) rd_slot <= rd_slot + 1'b1;
      if (commit && !read) level <= level + 1'b1;
      else if (!commit && read) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !flush) mem[wr_slot][idx] <= write_word;
`ifdef RECORD_FIFO_SHORT_RECORD_EN
    if (commit && !flush) len_mem[wr_slot] <= commit_len;
`endif
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < RECORD_WORDS; i++) begin
      bus.out_data[i*WORD_SIZE +: WORD_SIZE] = mem[rd_slot][i];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (level != '0);
  assign bus.level     = level;
  assign bus.full      = (level == LEVEL_MAX);
endmodule

// File: doc/record_fifo.md
# record_fifo

Word-in, record-out synchronous FIFO with valid/ready handshakes on both sides and slot-organised storage. It is the successor to the stream-to-record buffer between the byte-stream receiver and the motion/record consumers. It adds backpressure, reset, flush, short-record termination with padding, and a per-record valid-word count. Records are committed atomically: the consumer never sees a partially written record.

## Interface
- `WORD_SIZE`, default 8: bits per input word.
- `RECORD_WORDS`, default 16: words per record; power of 2, ≥2.
- `SLOTS`, default 8: record slots; power of 2, ≥2.
- `PAD_WORD`, default 0: value written into unused words of a short record.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all contents, including a partial record.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  FIFO accepts a word this cycle.
- `in_data`  in  WORD_SIZE  input word.
- `in_last`  in  1  with an accepted word: that word ends the record.
- `out_valid`  out  1  at least one committed record is available.
- `out_ready`  in  1  consumer takes the head record.
- `out_data`  out  WORD_SIZE*RECORD_WORDS  head record; word i at bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
- `out_len`  out  $clog2(RECORD_WORDS)+1  number of valid words in the head record (1..RECORD_WORDS).
- `level`  out  $clog2(SLOTS)+1  number of committed records.
- `full`  out  1  `level == SLOTS`.

## Operation
- Storage: SLOTS × RECORD_WORDS words, plus one length entry per slot. Write slot pointer, read slot pointer, word index, and `level` are registers.
- Write FSM has two states:
  - FILL: `in_ready = (level < SLOTS) && !flush`. An accepted word goes to [wr_slot][idx].
    - If `idx == RECORD_WORDS-1`: commit with length RECORD_WORDS. `in_last` is irrelevant here.
    - Else if `in_last`: go to PAD, latch length `idx+1`, `idx++`.
    - Else: `idx++`.
  - PAD: `in_ready = 0`. Write PAD_WORD at [wr_slot][idx] each cycle. At `idx == RECORD_WORDS-1`, commit and return to FILL.
- Commit: store the length, `wr_slot++` (mod SLOTS), `idx = 0`, `level++`.
- Read: `out_valid = (level != 0)`. `out_data` and `out_len` are a combinational view of slot rd_slot. On `out_valid && out_ready`, `rd_slot++` and `level--`.
- Commit and read in the same cycle: `level` is unchanged and both pointers advance.
- `out_ready` while `!out_valid` is ignored. `in_valid` while `!in_ready` is ignored; no overflow is possible.
- Pointer wrap: slot pointers wrap modulo SLOTS, and `level` alone distinguishes full from empty.
- Flush, which has priority over every other same-cycle event: pointers, `idx` and `level` go to 0 and state goes to FILL. A partial record is discarded, and the word or read offered in that cycle is not performed. Storage contents are not cleared.

## Timing
- Reset (async assert, sync release): `level = 0`, `full = 0`, `out_valid = 0`, state FILL, `idx = 0`, pointers 0. `in_ready` is forced 0 while `rst_n` is low. `out_data` and `out_len` are undefined while `out_valid` is 0.
- Reset asserted mid-record or mid-PAD: the partial record is lost and the state returns to FILL immediately.
- Write-to-read latency: a record committed at edge N has `out_valid` high in cycle N+1.
- PAD duration: a record ended by `in_last` on word k (0-based) holds `in_ready` low for RECORD_WORDS-1-k cycles. The commit happens on the last of those edges.
- Backpressure release: a read at edge N when full gives `in_ready` high in cycle N+1 (no same-cycle pass-through).
- Throughput: one word per cycle in and one record per cycle out, sustained.

## Configuration
- `RECORD_FIFO_SHORT_RECORD_EN` defined: `in_last` is honoured, the PAD state exists, and `out_len` reports the stored length.
- Not defined: `in_last` is ignored, there is no PAD state and no length storage, and `out_len` is the constant RECORD_WORDS. Records commit only after RECORD_WORDS accepted words.

## Test plan
Bench parameters: WORD_SIZE=8, RECORD_WORDS=4, SLOTS=2, PAD_WORD=8'hEE, macro defined unless stated.

- Write 0x01,0x02,0x03,0x04 with `out_ready=0` -> `out_valid` rises the cycle after the 4th accept; `out_data=32'h04030201`, `out_len=4`, `level=1`.
- Write 3 full records with `out_ready=0` -> `in_ready` drops after 8 words and `full=1`. One read gives `in_ready=1` the next cycle, and the 3rd record's words are then accepted.
- Write 0xAA with `in_last=1` -> `in_ready` is low for 3 cycles; the record reads `32'hEEEEEEAA` with `out_len=1`.
- Same stimulus with the macro undefined -> no PAD and no commit; after 3 more words the record commits with `out_len=4`.
- Hold `out_ready=1` and stream 4 records back-to-back -> records emerge in order and `level` never exceeds 1. Slot pointers wrap correctly after slot 1.
- Assert `flush` mid-record (2 words in), then separately pulse `rst_n` low during PAD -> `level=0` and `out_valid=0`. The next record starts at word index 0 and contains no stale words.
